// File: rtl/two_addr_useq_ctrl.sv
// Two-address microcode sequencer: writable store, per-step condition picks next address A or B.
// Optional watchdog step limit is compiled in when USEQ_WDOG_EN is defined.
module two_addr_useq_ctrl #(
  parameter int ADDR_W     = 3,
  parameter int CTRL_W     = 8,
  parameter int NCOND      = 4,
  parameter int START_ADDR = 0,
  parameter int MAX_STEPS  = 64,
  localparam int CSEL_W    = (NCOND > 1) ? $clog2(NCOND) : 1,
  localparam int W         = CTRL_W + CSEL_W + 2 * ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic [NCOND-1:0]  cond,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [W-1:0]      cfg_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              step_en,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [ADDR_W-1:0] upc
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] upc_q, upc_nx;
  logic              err_q, err_nx;
  logic              wdog_hit;

  logic [W-1:0]      store [2**ADDR_W];
  logic [W-1:0]      word;
  logic [CTRL_W-1:0] w_ctrl;
  logic [CSEL_W-1:0] w_csel;
  logic [ADDR_W-1:0] w_a, w_b;
  logic              w_last;
  logic [2**CSEL_W-1:0] cond_ext;

  assign word = store[upc_q];
  assign {w_ctrl, w_csel, w_a, w_b, w_last} = word;
  assign upc  = upc_q;
  assign err  = err_q;

  // Zero padding makes any csel >= NCOND select a constant 0 (address A).
  always_comb begin
    cond_ext = '0;
    cond_ext[NCOND-1:0] = cond;
  end

  // Store has no reset; only the host may write it, and only while idle.
  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE)
      store[cfg_addr] <= cfg_wdata;
  end

`ifdef USEQ_WDOG_EN
  localparam int CNT_W = $clog2(MAX_STEPS + 1);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (state == IDLE && start)
      cnt_q <= '0;
    else if (step_en)
      cnt_q <= cnt_q + 1'b1;
  end

  // True on the commit that would bring the count up to MAX_STEPS.
  assign wdog_hit = (cnt_q == CNT_W'(MAX_STEPS - 1));
`else
  // Watchdog compiled out: never fires.
  assign wdog_hit = (MAX_STEPS < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      upc_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      upc_q <= upc_nx;
      err_q <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    upc_nx   = upc_q;
    err_nx   = err_q;
    busy     = 1'b0;
    done     = 1'b0;
    step_en  = 1'b0;
    ctrl_out = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          upc_nx   = ADDR_W'(START_ADDR);
        end
      end
      RUN: begin
        busy     = 1'b1;
        ctrl_out = w_ctrl;
        if (!stall) begin
          step_en = 1'b1;
          if (w_last) begin
            state_nx = DONE;
          end else if (wdog_hit) begin
            state_nx = DONE;
            err_nx   = 1'b1;
          end else begin
            upc_nx = cond_ext[w_csel] ? w_b : w_a;
          end
        end
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        err_nx   = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_two_addr_useq_ctrl.sv
// Bench for two_addr_useq_ctrl: directed scenarios plus random programs checked
// against a program-walk reference model.
module tb_two_addr_useq_ctrl;
  localparam int ADDR_W = 3, CTRL_W = 8, NCOND = 4, CSEL_W = 2;
  localparam int START_ADDR = 0, MAX_STEPS = 64;
  localparam int W = CTRL_W + CSEL_W + 2 * ADDR_W + 1;
`ifdef USEQ_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, start, stall, cfg_we;
  logic [NCOND-1:0] cond;
  logic [ADDR_W-1:0] cfg_addr;
  logic [W-1:0] cfg_wdata;
  logic busy, done, err, step_en;
  logic [CTRL_W-1:0] ctrl_out;
  logic [ADDR_W-1:0] upc;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] ctrl;
    int csel;
    int a;
    int b;
    bit last;
  } uword_t;
  uword_t prog [8];

  always #5 clk = ~clk;

  two_addr_useq_ctrl #(
    .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .NCOND(NCOND),
    .START_ADDR(START_ADDR), .MAX_STEPS(MAX_STEPS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .cond(cond),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .busy(busy), .done(done), .err(err), .step_en(step_en),
    .ctrl_out(ctrl_out), .upc(upc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a word on the config port and records it in the model; no clock.
  task automatic stage(input int adr, input logic [7:0] c, input int cs,
                       input int a, input int b, input bit last);
    prog[adr] = '{c, cs, a, b, last};
    cfg_we    = 1'b1;
    cfg_addr  = adr[2:0];
    cfg_wdata = {c, 2'(cs), 3'(a), 3'(b), last};
  endtask

  task automatic load(input int adr, input logic [7:0] c, input int cs,
                      input int a, input int b, input bit last);
    stage(adr, c, cs, a, b, last);
    tick();
    cfg_we = 1'b0;
  endtask

  // Starts a run and checks every cycle against a walk of the model program.
  task automatic run(input string tag, input bit rnd_cond, input logic [3:0] cond_fix,
                     input int stall_pct, input int stall_pc, input bit noise,
                     output int cycles);
    int pc, steps, stall_left;
    bit fin, exp_err, st;
    logic [3:0] cv;
    pc = START_ADDR; steps = 0; fin = 1'b0; exp_err = 1'b0; cycles = 0; stall_left = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
    while (!fin && cycles < 200) begin
      cv = rnd_cond ? 4'($urandom) : cond_fix;
      if (stall_pc >= 0) st = (pc == stall_pc) && (stall_left > 0);
      else st = ($urandom_range(99) < stall_pct);
      if (st && stall_pc >= 0) stall_left--;
      stall = st;
      cond  = cv;
      if (noise) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd2; cfg_wdata = W'($urandom);
      end
      #1;
      chk({tag, " busy"}, busy, 1);
      chk({tag, " done_early"}, done, 0);
      chk({tag, " upc"}, upc, pc);
      chk({tag, " ctrl_out"}, ctrl_out, prog[pc].ctrl);
      chk({tag, " step_en"}, step_en, !st);
      if (!st) begin
        steps++;
        if (prog[pc].last) fin = 1'b1;
        else if (WDOG && steps == MAX_STEPS) begin fin = 1'b1; exp_err = 1'b1; end
        else pc = (prog[pc].csel < NCOND && cv[prog[pc].csel]) ? prog[pc].b : prog[pc].a;
      end
      tick();
      cycles++;
    end
    chk({tag, " finished"}, fin, 1);
    stall = 1'b0;
    #1;
    chk({tag, " done"}, done, 1);
    chk({tag, " busy_done"}, busy, 1);
    chk({tag, " ctrl_done"}, ctrl_out, 0);
    chk({tag, " step_done"}, step_en, 0);
    chk({tag, " err"}, err, exp_err);
    tick();
    start = 1'b0; cfg_we = 1'b0;
    #1;
    chk({tag, " busy_after"}, busy, 0);
    chk({tag, " done_after"}, done, 0);
    chk({tag, " err_after"}, err, 0);
    chk({tag, " ctrl_after"}, ctrl_out, 0);
  endtask

  task automatic load_t1();
    load(0, 8'h11, 0, 1, 1, 1'b0);
    load(1, 8'h22, 0, 2, 2, 1'b0);
    load(2, 8'h33, 0, 0, 0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; cfg_we = 1'b0;
    cond = '0; cfg_addr = '0; cfg_wdata = '0;
    #3;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst step_en", step_en, 0);
    chk("rst ctrl_out", ctrl_out, 0);
    chk("rst upc", upc, 0);
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();

    // Straight-line three-word program.
    load_t1();
    run("t1", 1'b0, 4'h0, 0, -1, 1'b0, cyc);
    chk("t1 cycles", cyc, 3);

    // Three stalled cycles on word 1 delay completion by three.
    run("t3", 1'b0, 4'h0, 0, 1, 1'b0, cyc);
    chk("t3 cycles", cyc, 6);

    // Config writes and start pulses while busy are ignored.
    run("t4_noise", 1'b0, 4'h0, 0, -1, 1'b1, cyc);
    run("t4_rerun", 1'b0, 4'h0, 0, -1, 1'b0, cyc);
    chk("t4 cycles", cyc, 3);

    // Condition-selected branch from word 0.
    load(0, 8'hA0, 2, 3, 5, 1'b0);
    load(3, 8'hA3, 0, 0, 0, 1'b1);
    load(5, 8'hA5, 0, 0, 0, 1'b1);
    run("t2_b", 1'b0, 4'b0100, 0, -1, 1'b0, cyc);
    run("t2_a", 1'b0, 4'b0000, 0, -1, 1'b0, cyc);

    // Asynchronous reset mid-run, then recovery.
    load_t1();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5 busy", busy, 0);
    chk("t5 ctrl_out", ctrl_out, 0);
    chk("t5 step_en", step_en, 0);
    chk("t5 upc", upc, 0);
    chk("t5 done", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5 no_done", done, 0);
    end
    #2 rst_n = 1'b1;
    tick();
    chk("t5 idle_busy", busy, 0);
    run("t5_restart", 1'b0, 4'h0, 0, -1, 1'b0, cyc);
    chk("t5 cycles", cyc, 3);

    // Random forward-only programs, random conditions and stalls; the final
    // word is written in the same cycle as start.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 7; i++)
        load(i, 8'($urandom), $urandom_range(3), $urandom_range(7, i + 1),
             $urandom_range(7, i + 1), ($urandom_range(7) == 0));
      stage(7, 8'($urandom), $urandom_range(3), 0, 0, 1'b1);
      run("rand", 1'b1, 4'h0, 30, -1, 1'b0, cyc);
    end

    // Self-loop on word 0.
    load(0, 8'h5A, 0, 0, 0, 1'b0);
    if (WDOG) begin
      run("t6_wdog", 1'b0, 4'hF, 0, -1, 1'b0, cyc);
      chk("t6 cycles", cyc, MAX_STEPS);
    end else begin
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 200; i++) begin
        #1;
        chk("t6 busy", busy, 1);
        chk("t6 done", done, 0);
        tick();
      end
      #2 rst_n = 1'b0;
      #1;
      chk("t6 rst_busy", busy, 0);
      #4 rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
